up2_uart_tx: RTL

- Buffered UART transmitter for the up2 board. It serialises bytes from on-chip logic onto the board `tx` pin.
- It replaces the direct rx-to-tx loopback with a real 8N1 serial source, so memory-read data can go back to the host.
- It sits beside the board top-level and drives `tx` directly (registered output). Upstream logic pushes bytes through a valid/ready handshake into a small FIFO.

---
 rtl/up2_uart_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/up2_uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a registered tx shifter.
// Define UP2_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module up2_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic               valid,
  output logic               ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   level
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH != (1 << FIFO_AW)) begin : g_bad_depth
      $error("FIFO_DEPTH must equal 2**FIFO_AW");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("CLKS_PER_BIT must be 2 or more");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UP2_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
`ifdef UP2_UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic               w_push;
  logic               w_pop;
  logic               w_bit_end;
  logic [7:0]         w_head;

  assign ready     = (r_level != LVL_FULL);
  assign w_push    = valid && ready;
  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_head    = r_mem[r_rd_ptr];
  // Pop from IDLE, or at the end of STOP so the next frame starts with no idle gap.
  assign w_pop     = (r_level != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign tx    = r_tx;
  assign level = r_level;
  assign busy  = (r_state != S_IDLE) || (r_level != '0);

  // Storage needs no reset; occupancy is carried by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
`ifdef UP2_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (w_pop) begin
            r_shift  <= w_head;
`ifdef UP2_UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_state  <= S_START;
            r_tx     <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
`ifdef UP2_UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

`ifdef UP2_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift  <= w_head;
`ifdef UP2_UART_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_state  <= S_START;
              r_tx     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
